sprite_line_scheduler: RTL and testbench

- Per-scanline sequencer for the character sprite ROM datapath (the army/enemy pixel lookup blocks with per-type ROMs and ctype mux).
- On each line_start it walks the character slot table and skips empty slots. For every slot whose sprite covers the current line, it issues one ROM address per sprite column.
- It realigns the ROM read data with the issued coordinates and writes opaque pixels into the display line buffer.
- Sits between the game-state slot table and the VGA line buffer.

---
 rtl/sprite_line_scheduler_if.sv | 45 ++++
 rtl/sprite_line_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scheduler_if.sv
// Bundle of the slot-table, pixel-ROM and line-buffer signals around the sprite line scheduler.
// master = scheduler side, slave = slot table / ROM / line buffer side.
interface sprite_line_scheduler_if #(
  parameter int unsigned NSLOT = 16,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 10
);
  localparam int unsigned IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic          line_start;
  logic [YW-1:0] line_y;
  logic [IW-1:0] slot_idx;
  logic [2:0]    slot_state;
  logic          slot_side;
  logic [2:0]    slot_ctype;
  logic [XW-1:0] slot_x;
  logic [YW-1:0] slot_y;
  logic [6:0]    slot_w;
  logic [6:0]    slot_h;
  logic          rom_side;
  logic [2:0]    rom_ctype;
  logic [12:0]   rom_addr;
  logic [1:0]    rom_pixel;
  logic          lb_we;
  logic [XW-1:0] lb_addr;
  logic [2:0]    lb_data;
  logic          busy;
  logic          done;

  modport master (
    input  line_start, line_y,
    input  slot_state, slot_side, slot_ctype, slot_x, slot_y, slot_w, slot_h,
    input  rom_pixel,
    output slot_idx, rom_side, rom_ctype, rom_addr,
    output lb_we, lb_addr, lb_data, busy, done
  );

  modport slave (
    output line_start, line_y,
    output slot_state, slot_side, slot_ctype, slot_x, slot_y, slot_w, slot_h,
    output rom_pixel,
    input  slot_idx, rom_side, rom_ctype, rom_addr,
    input  lb_we, lb_addr, lb_data, busy, done
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: scans the slot table, issues one pixel-ROM address per
// covered sprite column and writes opaque pixels to the line buffer after the ROM latency.
module sprite_line_scheduler #(
  parameter int unsigned NSLOT   = 16,
  parameter int unsigned ROM_LAT = 2,
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  sprite_line_scheduler_if.master  bus
);

  localparam int unsigned IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [IW-1:0] LAST_SLOT  = IW'(NSLOT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    DRAW,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic          valid;
    logic          side;
    logic [XW-1:0] x;
  } tap_t;

  state_e        state_q, state_d;
  logic [YW-1:0] ly_q, ly_d;
  logic [IW-1:0] slot_idx_q, slot_idx_d;
  logic [XW-1:0] x_q, x_d;
  logic [6:0]    w_q, w_d;
  logic [6:0]    col_q, col_d;
  logic          rom_side_q, rom_side_d;
  logic [2:0]    rom_ctype_q, rom_ctype_d;
  logic [12:0]   rom_addr_q, rom_addr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  tap_t          pipe_q [ROM_LAT];
  tap_t          push;
  tap_t          head;

  // Slot coverage test at YW+1 bits so slot_y+slot_h never wraps.
  logic [YW:0]   ly_ext, y_lo, y_hi;
  logic          hit;
  logic [6:0]    row;
  logic [XW:0]   xc;

  always_comb begin
    ly_ext = {1'b0, ly_q};
    y_lo   = {1'b0, bus.slot_y};
    y_hi   = y_lo + (YW+1)'(bus.slot_h);
    hit    = (bus.slot_state != 3'd0) && (ly_ext >= y_lo) && (ly_ext < y_hi);
    row    = 7'(ly_ext - y_lo);
    xc     = {1'b0, x_q} + (XW+1)'(col_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ly_q        <= '0;
      slot_idx_q  <= '0;
      x_q         <= '0;
      w_q         <= '0;
      col_q       <= '0;
      rom_side_q  <= 1'b0;
      rom_ctype_q <= '0;
      rom_addr_q  <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ly_q        <= ly_d;
      slot_idx_q  <= slot_idx_d;
      x_q         <= x_d;
      w_q         <= w_d;
      col_q       <= col_d;
      rom_side_q  <= rom_side_d;
      rom_ctype_q <= rom_ctype_d;
      rom_addr_q  <= rom_addr_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ly_d        = ly_q;
    slot_idx_d  = slot_idx_q;
    x_d         = x_q;
    w_d         = w_q;
    col_d       = col_q;
    rom_side_d  = rom_side_q;
    rom_ctype_d = rom_ctype_q;
    rom_addr_d  = rom_addr_q;
    drain_d     = drain_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          ly_d       = bus.line_y;
          slot_idx_d = '0;
          state_d    = SLOT;
        end
      end
      SLOT: begin
        if (hit) begin
          rom_side_d  = bus.slot_side;
          rom_ctype_d = bus.slot_ctype;
          x_d         = bus.slot_x;
          w_d         = bus.slot_w;
          col_d       = '0;
          // Base address row*w is formed once per slot; columns then just increment it.
          rom_addr_d  = 13'(row * bus.slot_w);
          state_d     = DRAW;
        end else if (slot_idx_q == LAST_SLOT) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          slot_idx_d = slot_idx_q + 1'b1;
        end
      end
      DRAW: begin
        if (col_q == w_q - 7'd1) begin
          if (slot_idx_q == LAST_SLOT) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            slot_idx_d = slot_idx_q + 1'b1;
            state_d    = SLOT;
          end
        end else begin
          col_d      = col_q + 7'd1;
          rom_addr_d = rom_addr_q + 13'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SLOT) || (state_d == DRAW) || (state_d == DRAIN);
  end

  // Delay line aligns each issued column with the ROM data returned ROM_LAT cycles later.
  always_comb begin
    push.valid = (state_q == DRAW) && !xc[XW];
    push.side  = rom_side_q;
    push.x     = xc[XW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= push;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head = pipe_q[ROM_LAT-1];

  // Pixel value 2'b11 is transparent and leaves the line buffer untouched.
  always_comb begin
    bus.lb_we   = head.valid && (bus.rom_pixel != 2'b11);
    bus.lb_addr = bus.lb_we ? head.x : '0;
    bus.lb_data = bus.lb_we ? {head.side, bus.rom_pixel} : '0;
  end

  assign bus.slot_idx  = slot_idx_q;
  assign bus.rom_side  = rom_side_q;
  assign bus.rom_ctype = rom_ctype_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: slot table and 2-cycle pixel ROM models,
// line-buffer write logging, hand-computed expectations.
module tb_sprite_line_scheduler;

  localparam int unsigned NSLOT   = 16;
  localparam int unsigned ROM_LAT = 2;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sprite_line_scheduler_if #(.NSLOT(NSLOT), .XW(XW), .YW(YW)) bus ();

  sprite_line_scheduler #(
    .NSLOT  (NSLOT),
    .ROM_LAT(ROM_LAT),
    .XW     (XW),
    .YW     (YW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Slot table model
  logic [2:0]    st_state [NSLOT];
  logic          st_side  [NSLOT];
  logic [2:0]    st_ctype [NSLOT];
  logic [XW-1:0] st_x     [NSLOT];
  logic [YW-1:0] st_y     [NSLOT];
  logic [6:0]    st_w     [NSLOT];
  logic [6:0]    st_h     [NSLOT];

  always_comb begin
    bus.slot_state = st_state[bus.slot_idx];
    bus.slot_side  = st_side[bus.slot_idx];
    bus.slot_ctype = st_ctype[bus.slot_idx];
    bus.slot_x     = st_x[bus.slot_idx];
    bus.slot_y     = st_y[bus.slot_idx];
    bus.slot_w     = st_w[bus.slot_idx];
    bus.slot_h     = st_h[bus.slot_idx];
  end

  // Pixel ROM model, two register stages
  int          pix_mode;
  logic [12:0] a1, a2;
  logic        s1, s2;

  always @(posedge clk) begin
    a1 <= bus.rom_addr;
    s1 <= bus.rom_side;
    a2 <= a1;
    s2 <= s1;
  end

  always_comb begin
    if (pix_mode == 1) bus.rom_pixel = a2[0] ? 2'b10 : 2'b11;
    else               bus.rom_pixel = s2 ? 2'b10 : 2'b01;
  end

  // Monitor: sampled on the falling edge
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  cyc;
  int  done_cnt;
  int  rom_hist   [8192];
  int  ctype_hist [8192];
  int  linebuf    [1024];

  initial begin
    cyc      = 0;
    done_cnt = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc < 8192) begin
      rom_hist[cyc]   = int'(bus.rom_addr);
      ctype_hist[cyc] = int'(bus.rom_ctype);
    end
    if (bus.done) done_cnt = done_cnt + 1;
    if (bus.lb_we) begin
      wq.push_back('{addr: int'(bus.lb_addr), data: int'(bus.lb_data), cyc: cyc});
      linebuf[bus.lb_addr] = int'(bus.lb_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NSLOT; i++) begin
      st_state[i] = 3'd0;
      st_side[i]  = 1'b0;
      st_ctype[i] = 3'd0;
      st_x[i]     = '0;
      st_y[i]     = '0;
      st_w[i]     = 7'd1;
      st_h[i]     = 7'd1;
    end
  endtask

  task automatic set_slot(input int idx, input int side, input int ctype, input int x,
                          input int y, input int w, input int h);
    st_state[idx] = 3'd1;
    st_side[idx]  = side[0];
    st_ctype[idx] = 3'(ctype);
    st_x[idx]     = XW'(x);
    st_y[idx]     = YW'(y);
    st_w[idx]     = 7'(w);
    st_h[idx]     = 7'(h);
  endtask

  // Runs one line; cycles = rising edges from the one sampling line_start to the first done.
  task automatic run_line(input int ly, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    wq.delete();
    for (int i = 0; i < 1024; i++) linebuf[i] = -1;
    @(negedge clk);
    bus.line_y     = YW'(ly);
    bus.line_start = 1'b1;
    while (!seen && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      bus.line_start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check_eq("done_timeout", 0, 1);
    @(negedge clk);
    check_eq("done_width", int'(bus.done), 0);
  endtask

  int cycles;
  int dc;

  initial begin
    rst            = 1'b1;
    bus.line_start = 1'b0;
    bus.line_y     = '0;
    pix_mode       = 0;
    clear_table();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_slot_idx", int'(bus.slot_idx), 0);
    check_eq("rst_rom_addr", int'(bus.rom_addr), 0);
    check_eq("rst_lb_we", int'(bus.lb_we), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);

    // Empty table: no writes, done NSLOT+ROM_LAT+2 edges after line_start
    run_line(50, cycles);
    check_eq("empty_cycles", cycles, 20);
    check_eq("empty_writes", wq.size(), 0);

    // Single army sprite, row 5 of an 8-wide sprite -> addresses 40..47
    set_slot(3, 0, 1, 100, 40, 8, 10);
    run_line(45, cycles);
    check_eq("hit_cycles", cycles, 28);
    check_eq("hit_writes", wq.size(), 8);
    if (wq.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        check_eq($sformatf("hit_addr%0d", j), wq[j].addr, 100 + j);
        check_eq($sformatf("hit_data%0d", j), wq[j].data, 1);
        check_eq($sformatf("hit_cyc%0d", j), wq[j].cyc, wq[0].cyc + j);
        check_eq($sformatf("hit_rom%0d", j), rom_hist[wq[j].cyc - ROM_LAT], 40 + j);
        check_eq($sformatf("hit_ctype%0d", j), ctype_hist[wq[j].cyc - ROM_LAT], 1);
      end
    end

    // Line just past the bottom and just above the top
    run_line(50, cycles);
    check_eq("below_cycles", cycles, 20);
    check_eq("below_writes", wq.size(), 0);
    run_line(39, cycles);
    check_eq("above_cycles", cycles, 20);
    check_eq("above_writes", wq.size(), 0);

    // Overlap: enemy slot 2 at 200, army slot 5 at 204; later slot wins
    clear_table();
    set_slot(2, 1, 2, 200, 0, 8, 127);
    set_slot(5, 0, 3, 204, 0, 8, 127);
    run_line(10, cycles);
    check_eq("ovl_cycles", cycles, 36);
    check_eq("ovl_writes", wq.size(), 16);
    if (wq.size() == 16) check_eq("ovl_first_side", (wq[0].data >> 2) & 1, 1);
    check_eq("ovl_lb200", linebuf[200], 6);
    check_eq("ovl_lb203", linebuf[203], 6);
    check_eq("ovl_lb204", linebuf[204], 1);
    check_eq("ovl_lb207", linebuf[207], 1);
    check_eq("ovl_lb211", linebuf[211], 1);
    check_eq("ovl_lb212", linebuf[212], -1);

    // Even columns transparent
    clear_table();
    set_slot(3, 0, 1, 100, 40, 8, 10);
    pix_mode = 1;
    run_line(45, cycles);
    check_eq("transp_writes", wq.size(), 4);
    if (wq.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("transp_addr%0d", j), wq[j].addr, 101 + 2 * j);
        check_eq($sformatf("transp_data%0d", j), wq[j].data, 2);
      end
    end
    pix_mode = 0;

    // Right-edge clipping
    set_slot(3, 0, 1, 1020, 40, 8, 10);
    run_line(45, cycles);
    check_eq("clip_cycles", cycles, 28);
    check_eq("clip_writes", wq.size(), 4);
    if (wq.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("clip_addr%0d", j), wq[j].addr, 1020 + j);
      end
    end

    // Reset three cycles into a DRAW, then a normal line
    set_slot(3, 0, 1, 100, 40, 8, 10);
    @(negedge clk);
    bus.line_y     = YW'(45);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    check_eq("abort_lb_we", int'(bus.lb_we), 0);
    check_eq("abort_busy", int'(bus.busy), 0);
    check_eq("abort_done", int'(bus.done), 0);
    wq.delete();
    repeat (10) @(negedge clk);
    check_eq("abort_writes", wq.size(), 0);
    check_eq("abort_no_done", done_cnt, dc);

    run_line(45, cycles);
    check_eq("rerun_cycles", cycles, 28);
    check_eq("rerun_writes", wq.size(), 8);
    if (wq.size() == 8) check_eq("rerun_last_addr", wq[7].addr, 107);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
